// File: rtl/paillier_operand_loader.sv
// Operand loader: host-filled g/m/r/n/c/lambda buffers streamed word-serially
// to the Paillier top after a task_req handshake.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data  host buffer write (sel 0..5, addr < N)
//   start, cmd                 task start (0 encrypt, 1 decrypt)
//   ds_ready                   downstream top can accept task_req
//   task_req, task_cmd         one-cycle request and latched command
//   enc_*_data/valid           encrypt operand words (g, m, r, n)
//   dec_*_data/valid           decrypt operand words (c, lambda, n)
//   busy, done, err            status, completion pulse, rejection pulse
module paillier_operand_loader #(
  parameter int K         = 128,
  parameter int N         = 32,
  parameter int START_GAP = 2,
  localparam int AW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [2:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [K-1:0]  wr_data,
  input  logic          start,
  input  logic [2:0]    cmd,
  input  logic          ds_ready,
  output logic          task_req,
  output logic [2:0]    task_cmd,
  output logic [K-1:0]  enc_g_data,
  output logic [K-1:0]  enc_m_data,
  output logic [K-1:0]  enc_r_data,
  output logic [K-1:0]  enc_n_data,
  output logic          enc_g_valid,
  output logic          enc_m_valid,
  output logic          enc_r_valid,
  output logic          enc_n_valid,
  output logic [K-1:0]  dec_c_data,
  output logic [K-1:0]  dec_lambda_data,
  output logic [K-1:0]  dec_n_data,
  output logic          dec_c_valid,
  output logic          dec_lambda_valid,
  output logic          dec_n_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        state;
  logic [K-1:0]  mem [6][N];
  logic [K-1:0]  rd [6];
  logic [5:0]    loaded;
  logic [AW-1:0] cnt;
  logic [3:0]    gcnt;
  logic [AW-1:0] raddr;
  logic          idle;
  logic          sel_ok;
  logic          wr_ok;
  logic          wr_bad;
  logic          cmd_ok;
  logic          start_ok;
  logic          start_bad;
  logic          emit;

  assign idle      = (state == S_IDLE);
  assign sel_ok    = (wr_sel <= 3'd5) &&
                     ({1'b0, wr_addr} < (AW+1)'(N));
  assign wr_ok     = wr_en & idle & sel_ok;
  assign wr_bad    = wr_en & ~(idle & sel_ok);
  assign start_ok  = start & idle & cmd_ok;
  assign start_bad = start & idle & ~cmd_ok;

  // Flags are the registered values, so a same-cycle write cannot
  // satisfy its own start.
  always_comb begin
    cmd_ok = 1'b0;
    unique case (1'b1)
      (cmd == 3'd0): cmd_ok = &loaded[3:0];
      (cmd == 3'd1): cmd_ok = loaded[4] & loaded[5] & loaded[3];
      default:       cmd_ok = 1'b0;
    endcase
  end

  // Output registers load the word shown next cycle: word 0 on the
  // last GAP cycle, word cnt+1 while streaming.
  assign emit  = ((state == S_GAP) && (gcnt == 4'd0)) ||
                 ((state == S_STREAM) && (cnt != AW'(N-1)));
  assign raddr = (state == S_STREAM) ? cnt + 1'b1 : '0;

  always_comb begin
    for (int b = 0; b < 6; b++) rd[b] = mem[b][raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 6; b++)
        if (wr_sel == 3'(b)) mem[b][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      loaded           <= '0;
      cnt              <= '0;
      gcnt             <= '0;
      task_req         <= 1'b0;
      task_cmd         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      enc_g_valid      <= 1'b0;
      enc_m_valid      <= 1'b0;
      enc_r_valid      <= 1'b0;
      enc_n_valid      <= 1'b0;
      enc_g_data       <= '0;
      enc_m_data       <= '0;
      enc_r_data       <= '0;
      enc_n_data       <= '0;
      dec_c_valid      <= 1'b0;
      dec_lambda_valid <= 1'b0;
      dec_n_valid      <= 1'b0;
      dec_c_data       <= '0;
      dec_lambda_data  <= '0;
      dec_n_data       <= '0;
    end else begin
      task_req         <= 1'b0;
      done             <= 1'b0;
      err              <= wr_bad | start_bad;
      enc_g_valid      <= 1'b0;
      enc_m_valid      <= 1'b0;
      enc_r_valid      <= 1'b0;
      enc_n_valid      <= 1'b0;
      enc_g_data       <= '0;
      enc_m_data       <= '0;
      enc_r_data       <= '0;
      enc_n_data       <= '0;
      dec_c_valid      <= 1'b0;
      dec_lambda_valid <= 1'b0;
      dec_n_valid      <= 1'b0;
      dec_c_data       <= '0;
      dec_lambda_data  <= '0;
      dec_n_data       <= '0;
      if (wr_ok && wr_addr == AW'(N-1))
        loaded[wr_sel] <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            task_cmd <= cmd;
            busy     <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ds_ready) begin
            task_req <= 1'b1;
            gcnt     <= 4'(START_GAP - 1);
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (gcnt == 4'd0) begin
            cnt   <= '0;
            state <= S_STREAM;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        S_STREAM: begin
          if (cnt == AW'(N-1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (emit) begin
        if (task_cmd[0]) begin
          dec_c_valid      <= 1'b1;
          dec_lambda_valid <= 1'b1;
          dec_n_valid      <= 1'b1;
          dec_c_data       <= rd[4];
          dec_lambda_data  <= rd[5];
          dec_n_data       <= rd[3];
        end else begin
          enc_g_valid <= 1'b1;
          enc_m_valid <= 1'b1;
          enc_r_valid <= 1'b1;
          enc_n_valid <= 1'b1;
          enc_g_data  <= rd[0];
          enc_m_data  <= rd[1];
          enc_r_data  <= rd[2];
          enc_n_data  <= rd[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_paillier_operand_loader.sv
// Bench for paillier_operand_loader (K=8, N=4, START_GAP=2).
// Table vectors, directed corner sequences and a random phase vs a model.
module tb_paillier_operand_loader;

  localparam int K = 8;
  localparam int N = 4;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_sel = '0;
  logic [1:0]   wr_addr = '0;
  logic [K-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic [2:0]   cmd = '0;
  logic         ds_ready = 1'b0;
  logic         task_req;
  logic [2:0]   task_cmd;
  logic [K-1:0] enc_g_data, enc_m_data, enc_r_data, enc_n_data;
  logic         enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid;
  logic [K-1:0] dec_c_data, dec_lambda_data, dec_n_data;
  logic         dec_c_valid, dec_lambda_valid, dec_n_valid;
  logic         busy, done, err;

  paillier_operand_loader #(.K(K), .N(N), .START_GAP(G)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .cmd(cmd), .ds_ready(ds_ready),
    .task_req(task_req), .task_cmd(task_cmd),
    .enc_g_data(enc_g_data), .enc_m_data(enc_m_data),
    .enc_r_data(enc_r_data), .enc_n_data(enc_n_data),
    .enc_g_valid(enc_g_valid), .enc_m_valid(enc_m_valid),
    .enc_r_valid(enc_r_valid), .enc_n_valid(enc_n_valid),
    .dec_c_data(dec_c_data), .dec_lambda_data(dec_lambda_data),
    .dec_n_data(dec_n_data),
    .dec_c_valid(dec_c_valid), .dec_lambda_valid(dec_lambda_valid),
    .dec_n_valid(dec_n_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: buffer contents and loaded flags.
  logic [K-1:0] mm [6][N];
  bit   [5:0]   fl;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    bit       we;
    bit [2:0] sel;
    bit [1:0] addr;
    bit [7:0] d;
    bit       st;
    bit [2:0] c;
    bit       e_err;
  } vec_t;

  vec_t tbl [8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] obs();
    return {61'b0,
            enc_g_valid, enc_m_valid, enc_r_valid, enc_n_valid,
            enc_g_data, enc_m_data, enc_r_data, enc_n_data,
            dec_c_valid, dec_lambda_valid, dec_n_valid,
            dec_c_data, dec_lambda_data, dec_n_data,
            task_req, done, busy, err};
  endfunction

  function automatic logic [127:0] ev(input bit e, input bit d, input int i,
                                      input bit tr, input bit dn,
                                      input bit bz, input bit er);
    logic [31:0] ed;
    logic [23:0] dd;
    int j;
    j  = (i >= 0 && i < N) ? i : 0;
    ed = '0;
    dd = '0;
    if (e) ed = {mm[0][j], mm[1][j], mm[2][j], mm[3][j]};
    if (d) dd = {mm[4][j], mm[5][j], mm[3][j]};
    return {61'b0, {4{e}}, ed, {3{d}}, dd, tr, dn, bz, er};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    fl = '0;
  endtask

  task automatic wr(input bit [2:0] s, input bit [1:0] a,
                    input bit [7:0] d);
    wr_en = 1'b1;
    wr_sel = s;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    chk("wr_err", obs(), ev(0, 0, 0, 0, 0, 0, s > 5));
    if (s <= 5) begin
      mm[s][a] = d;
      if (a == 2'(N-1)) fl[s] = 1'b1;
    end
  endtask

  task automatic wr_op(input int s, input bit [7:0] base);
    for (int a = 0; a < N; a++) wr(3'(s), 2'(a), base + 8'(a));
  endtask

  // One start command; timing derived from T = first task_req cycle.
  task automatic do_task(input bit [2:0] c, input int dly,
                         input bit inj, input bit rmid);
    bit ok;
    bit e;
    bit d;
    ok = (c == 0 && (&fl[3:0])) ||
         (c == 1 && fl[4] && fl[5] && fl[3]);
    e = (c == 0);
    d = (c == 1);
    start = 1'b1;
    cmd = c;
    ds_ready = (dly == 0);
    cyc();
    start = 1'b0;
    if (!ok) begin
      chk("start_rej", obs(), ev(0, 0, 0, 0, 0, 0, 1));
      cyc();
      chk("rej_after", obs(), ev(0, 0, 0, 0, 0, 0, 0));
      return;
    end
    chk("req_wait", obs(), ev(0, 0, 0, 0, 0, 1, 0));
    for (int k = 1; k < dly; k++) begin
      cyc();
      chk("stall", obs(), ev(0, 0, 0, 0, 0, 1, 0));
    end
    ds_ready = 1'b1;
    cyc();
    chk("task_req", obs(), ev(0, 0, 0, 1, 0, 1, 0));
    chk("task_cmd", {125'b0, task_cmd}, {125'b0, c});
    for (int t = 1; t <= G + N + 1; t++) begin
      wr_en = inj && (t == G + 2);
      wr_sel = '0;
      wr_addr = '0;
      wr_data = 8'hFF;
      rst = rmid && (t == G + 3);
      ds_ready = 1'($urandom_range(0, 1));
      cyc();
      wr_en = 1'b0;
      if (rmid && t == G + 3) begin
        rst = 1'b0;
        fl = '0;
        chk("rst_mid", obs(), 128'b0);
        chk("rst_cmd", {125'b0, task_cmd}, 128'b0);
        ds_ready = 1'b0;
        return;
      end
      chk($sformatf("stream_t%0d", t), obs(),
          ev(e && t >= G && t < G + N, d && t >= G && t < G + N, t - G,
             0, t == G + N, t <= G + N, inj && t == G + 2));
    end
    ds_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // we sel addr data st cmd err -- applied right after reset
    tbl[0] = '{1, 3'd6, 2'd0, 8'h00, 0, 3'd0, 1};
    tbl[1] = '{1, 3'd7, 2'd3, 8'h55, 0, 3'd0, 1};
    tbl[2] = '{0, 3'd0, 2'd0, 8'h00, 1, 3'd3, 1};
    tbl[3] = '{0, 3'd0, 2'd0, 8'h00, 1, 3'd2, 1};
    tbl[4] = '{0, 3'd0, 2'd0, 8'h00, 1, 3'd0, 1};
    tbl[5] = '{0, 3'd0, 2'd0, 8'h00, 1, 3'd1, 1};
    tbl[6] = '{1, 3'd0, 2'd0, 8'd11, 0, 3'd0, 0};
    tbl[7] = '{0, 3'd0, 2'd0, 8'h00, 0, 3'd0, 0};

    for (int b = 0; b < 6; b++)
      for (int a = 0; a < N; a++) mm[b][a] = '0;

    do_reset();
    chk("reset", obs(), 128'b0);
    chk("reset_cmd", {125'b0, task_cmd}, 128'b0);

    foreach (tbl[i]) begin
      wr_en = tbl[i].we;
      wr_sel = tbl[i].sel;
      wr_addr = tbl[i].addr;
      wr_data = tbl[i].d;
      start = tbl[i].st;
      cmd = tbl[i].c;
      cyc();
      wr_en = 1'b0;
      start = 1'b0;
      chk($sformatf("tbl%0d", i), obs(), ev(0, 0, 0, 0, 0, 0, tbl[i].e_err));
      if (tbl[i].we && tbl[i].sel <= 5) mm[tbl[i].sel][tbl[i].addr] = tbl[i].d;
    end

    // Missing r: g, m, n complete, r only words 0..2.
    wr_op(0, 8'd11);
    wr_op(1, 8'd21);
    wr_op(3, 8'd41);
    for (int a = 0; a < N - 1; a++) wr(3'd2, 2'(a), 8'd31 + 8'(a));
    do_task(3'd0, 0, 0, 0);

    // Same-cycle start and final r write: flag not yet seen, write kept.
    start = 1'b1;
    cmd = 3'd0;
    wr_en = 1'b1;
    wr_sel = 3'd2;
    wr_addr = 2'd3;
    wr_data = 8'd34;
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    chk("start_same_wr", obs(), ev(0, 0, 0, 0, 0, 0, 1));
    mm[2][3] = 8'd34;
    fl[2] = 1'b1;

    // Encrypt happy path, then decrypt with n reused.
    do_task(3'd0, 0, 0, 0);
    wr_op(4, 8'd51);
    wr_op(5, 8'd61);
    do_task(3'd1, 0, 0, 0);

    // Back-pressure with an illegal write mid-stream; buffers unchanged.
    do_task(3'd0, 10, 1, 0);
    do_task(3'd0, 2, 0, 0);
    do_task(3'd1, 1, 1, 0);

    // Randomized mix of writes and starts.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        wr(($urandom_range(0, 5) == 0) ? 3'($urandom_range(6, 7))
                                       : 3'($urandom_range(0, 5)),
           2'($urandom_range(0, N - 1)), 8'($urandom));
      end else begin
        do_task(($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 7))
                                            : 3'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 3) == 0, 0);
      end
    end

    // Reset mid-stream clears flags but not buffer contents.
    do_task(3'd0, 0, 0, 1);
    do_task(3'd0, 0, 0, 0);
    wr(3'd0, 2'd3, 8'h90);
    wr(3'd1, 2'd3, 8'h91);
    wr(3'd2, 2'd3, 8'h92);
    wr(3'd3, 2'd3, 8'h93);
    do_task(3'd0, 0, 0, 0);
    do_task(3'd1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
